// File: rtl/hazard_fwd_unit_pkg.sv
// Shared constants and pipeline shadow-stage type for the hazard/forwarding unit.
package hazard_fwd_unit_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic              regwrite;
        logic              load;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '{valid: 1'b0, dst: '0, regwrite: 1'b0, load: 1'b0};

endpackage

// File: rtl/hazard_fwd_unit_cmp.sv
// Qualified source/destination match: a used source hits a valid, writing,
// non-zero destination with the same register address.
module hazard_cmp
    import hazard_fwd_unit_pkg::*;
(
    input  logic              i_use,
    input  logic [REG_AW-1:0] i_src,
    input  logic              i_valid,
    input  logic              i_regwrite,
    input  logic [REG_AW-1:0] i_dst,
    output logic              o_hit
);

    assign o_hit = i_use & i_valid & i_regwrite & (i_dst != '0) & (i_dst == i_src);

endmodule

// File: rtl/hazard_fwd_unit.sv
// Load-use stall detection and registered EX operand-forwarding selects,
// tracking EX/MEM/WB with internal shadow registers.
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_regwrite,
    input  logic              id_load,
    input  logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic [15:0]       stall_count
);

    stage_t      r_ex;
    stage_t      r_mem;
    stage_t      r_wb;
    logic [1:0]  r_fwd_a;
    logic [1:0]  r_fwd_b;
    logic [15:0] r_stall_count;

    logic w_stall;
    logic w_hold;
    logic w_rs_ex;
    logic w_rs_mem;
    logic w_rt_ex;
    logic w_rt_mem;

    assign w_stall = r_ex.valid & r_ex.load & (r_ex.dst != '0) & id_valid &
                     ((id_uses_rs & (id_rs == r_ex.dst)) | (id_uses_rt & (id_rt == r_ex.dst)));
    assign w_hold  = flush | w_stall;

    hazard_cmp u_cmp_rs_ex (
        .i_use(id_uses_rs), .i_src(id_rs), .i_valid(r_ex.valid),
        .i_regwrite(r_ex.regwrite), .i_dst(r_ex.dst), .o_hit(w_rs_ex)
    );
    hazard_cmp u_cmp_rs_mem (
        .i_use(id_uses_rs), .i_src(id_rs), .i_valid(r_mem.valid),
        .i_regwrite(r_mem.regwrite), .i_dst(r_mem.dst), .o_hit(w_rs_mem)
    );
    hazard_cmp u_cmp_rt_ex (
        .i_use(id_uses_rt), .i_src(id_rt), .i_valid(r_ex.valid),
        .i_regwrite(r_ex.regwrite), .i_dst(r_ex.dst), .o_hit(w_rt_ex)
    );
    hazard_cmp u_cmp_rt_mem (
        .i_use(id_uses_rt), .i_src(id_rt), .i_valid(r_mem.valid),
        .i_regwrite(r_mem.regwrite), .i_dst(r_mem.dst), .o_hit(w_rt_mem)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex          <= STAGE_BUBBLE;
            r_mem         <= STAGE_BUBBLE;
            r_wb          <= STAGE_BUBBLE;
            r_fwd_a       <= FWD_RF;
            r_fwd_b       <= FWD_RF;
            r_stall_count <= '0;
        end else begin
            r_mem <= r_ex;
            r_wb  <= r_mem;
            if (w_hold) begin
                r_ex    <= STAGE_BUBBLE;
                r_fwd_a <= FWD_RF;
                r_fwd_b <= FWD_RF;
            end else begin
                r_ex.valid    <= id_valid;
                r_ex.dst      <= id_dst;
                r_ex.regwrite <= id_regwrite & id_valid;
                r_ex.load     <= id_load & id_valid;
                // Current EX moves to MEM next cycle, so it wins over current MEM.
                r_fwd_a <= w_rs_ex ? FWD_MEM : (w_rs_mem ? FWD_WB : FWD_RF);
                r_fwd_b <= w_rt_ex ? FWD_MEM : (w_rt_mem ? FWD_WB : FWD_RF);
            end
            if (w_stall && !flush && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign fwd_a       = r_fwd_a;
    assign fwd_b       = r_fwd_b;
    assign stall       = w_stall;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed pipeline scenarios with literal
// expectations, then randomized traffic against a history-based model.
module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic [4:0] id_dst;
    logic       id_regwrite;
    logic       id_load;
    logic       flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       stall;
    logic [15:0] stall_count;

    hazard_fwd_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_load(id_load), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: hist[0] is what sits in EX, hist[1] in MEM, hist[2] in WB.
    // A writer is any valid instruction that writes the register file.
    bit      h_wr[3];
    bit      h_ld[3];
    int      h_dst[3];
    int      m_fa;
    int      m_fb;
    int      m_cnt;
    int      obs_stall;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int src_sel(input bit use_it, input int src);
        if (!use_it || src == 0) return 0;
        if (h_wr[0] && h_dst[0] == src) return 2;
        if (h_wr[1] && h_dst[1] == src) return 1;
        return 0;
    endfunction

    function automatic bit model_stall();
        if (!id_valid || !h_ld[0] || h_dst[0] == 0) return 0;
        return (id_uses_rs && int'(id_rs) == h_dst[0]) || (id_uses_rt && int'(id_rt) == h_dst[0]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            h_wr[i] = 0; h_ld[i] = 0; h_dst[i] = 0;
        end
        m_fa = 0; m_fb = 0; m_cnt = 0;
    endtask

    // Drive one ID cycle (called at a negedge), check both around the posedge.
    task automatic step(input bit rn, input bit v, input int rs, input int rt,
                        input bit urs, input bit urt, input int dst,
                        input bit rw, input bit ld, input bit fl);
        bit ms;
        rst_n = rn; id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt);
        id_uses_rs = urs; id_uses_rt = urt; id_dst = 5'(dst);
        id_regwrite = rw; id_load = ld; flush = fl;
        #1;
        ms = model_stall();
        obs_stall = int'(stall);
        check("stall", int'(stall), int'(ms));
        @(posedge clk);
        if (!rn) begin
            model_clear();
        end else begin
            if (fl || ms) begin
                m_fa = 0; m_fb = 0;
            end else begin
                m_fa = src_sel(urs, rs);
                m_fb = src_sel(urt, rt);
            end
            if (ms && !fl && m_cnt < 65535) m_cnt++;
            for (int i = 2; i > 0; i--) begin
                h_wr[i] = h_wr[i-1]; h_ld[i] = h_ld[i-1]; h_dst[i] = h_dst[i-1];
            end
            h_wr[0]  = !(fl || ms) && v && rw;
            h_ld[0]  = !(fl || ms) && v && ld;
            h_dst[0] = (fl || ms) ? 0 : dst;
        end
        #1;
        check("fwd_a", int'(fwd_a), m_fa);
        check("fwd_b", int'(fwd_b), m_fb);
        check("stall_count", int'(stall_count), m_cnt);
        @(negedge clk);
    endtask

    task automatic nop();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int c0;

    initial begin
        model_clear();
        @(negedge clk);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset fwd_a", int'(fwd_a), 0);
        check("reset count", int'(stall_count), 0);
        nop();
        check("post-reset stall", obs_stall, 0);

        // ADD r3; SUB rs=r3
        step(1, 1, 1, 2, 1, 1, 3, 1, 0, 0);
        step(1, 1, 3, 1, 1, 1, 6, 1, 0, 0);
        check("b2b fwd_a", int'(fwd_a), 2);
        check("b2b fwd_b", int'(fwd_b), 0);

        // ADD r3; NOP; OR rt=r3
        step(1, 1, 1, 2, 1, 1, 3, 1, 0, 0);
        nop();
        step(1, 1, 1, 3, 1, 1, 7, 1, 0, 0);
        check("dist2 fwd_b", int'(fwd_b), 1);
        check("dist2 fwd_a", int'(fwd_a), 0);

        // ADD r5; ADD r5; AND rs=r5
        step(1, 1, 1, 2, 1, 1, 5, 1, 0, 0);
        step(1, 1, 1, 2, 1, 1, 5, 1, 0, 0);
        step(1, 1, 5, 2, 1, 1, 8, 1, 0, 0);
        check("double fwd_a", int'(fwd_a), 2);

        // LW r4; ADD rs=r4 (held one cycle by the stall)
        nop(); nop();
        c0 = int'(stall_count);
        step(1, 1, 1, 0, 1, 0, 4, 1, 1, 0);
        step(1, 1, 4, 2, 1, 1, 9, 1, 0, 0);
        check("lu stall", obs_stall, 1);
        check("lu bubble fwd_a", int'(fwd_a), 0);
        check("lu count", int'(stall_count), c0 + 1);
        step(1, 1, 4, 2, 1, 1, 9, 1, 0, 0);
        check("lu stall gone", obs_stall, 0);
        check("lu fwd_a", int'(fwd_a), 1);
        check("lu count once", int'(stall_count), c0 + 1);

        // LW r4; ADD rs=r4 with flush
        nop(); nop();
        c0 = int'(stall_count);
        step(1, 1, 1, 0, 1, 0, 4, 1, 1, 0);
        step(1, 1, 4, 4, 1, 1, 9, 1, 0, 1);
        check("flush stall seen", obs_stall, 1);
        check("flush fwd_a", int'(fwd_a), 0);
        check("flush fwd_b", int'(fwd_b), 0);
        check("flush count", int'(stall_count), c0);
        step(1, 1, 9, 9, 1, 1, 10, 1, 0, 0);
        check("flush bubble fwd_a", int'(fwd_a), 0);

        // r0 as destination: no forward, no stall
        step(1, 1, 1, 2, 1, 1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 1, 1, 11, 1, 1, 0);
        check("r0 fwd_a", int'(fwd_a), 0);
        check("r0 fwd_b", int'(fwd_b), 0);
        step(1, 1, 0, 0, 1, 1, 12, 1, 0, 0);
        check("r0 load no stall", obs_stall, 0);

        // reset in the middle of a load-use stall
        nop(); nop();
        step(1, 1, 1, 0, 1, 0, 4, 1, 1, 0);
        step(0, 1, 4, 2, 1, 1, 9, 1, 0, 0);
        check("rst stall before", obs_stall, 1);
        check("rst count", int'(stall_count), 0);
        check("rst fwd_a", int'(fwd_a), 0);
        step(1, 1, 4, 2, 1, 1, 9, 1, 0, 0);
        check("rst stall dropped", obs_stall, 0);
        check("rst fwd after", int'(fwd_a), 0);

        // randomized traffic; registers 0..3 to provoke hits, stalled ID usually held
        begin
            bit v, urs, urt, rw, ld, fl, rn;
            int rs, rt, dst;
            v = 0; rs = 0; rt = 0; urs = 0; urt = 0; dst = 0; rw = 0; ld = 0;
            for (int n = 0; n < 3000; n++) begin
                rn = ($urandom_range(63) != 0);
                fl = ($urandom_range(7) == 0);
                if (!(model_stall() && $urandom_range(3) != 0)) begin
                    v   = ($urandom_range(7) != 0);
                    rs  = $urandom_range(3);
                    rt  = $urandom_range(3);
                    urs = $urandom_range(1);
                    urt = $urandom_range(1);
                    dst = $urandom_range(3);
                    rw  = ($urandom_range(3) != 0);
                    ld  = rw && ($urandom_range(2) == 0);
                end
                step(rn, v, rs, rt, urs, urt, dst, rw, ld, fl);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 Port `clk`: input, 1 bit, rising-edge clock.
REQ-003 Port `rst_n`: input, 1 bit, synchronous active-low reset.
REQ-004 Port `id_valid`: input, 1 bit, ID stage holds a real instruction.
REQ-005 Ports `id_rs` and `id_rt`: input, 5 bits each, ID source register addresses.
REQ-006 Ports `id_uses_rs` and `id_uses_rt`: input, 1 bit each, instruction reads rs / rt.
REQ-007 Port `id_dst`: input, 5 bits, destination register after rd/rt selection.
REQ-008 Port `id_regwrite`: input, 1 bit, instruction writes the register file.
REQ-009 Port `id_load`: input, 1 bit, instruction is a load (memtoreg).
REQ-010 Port `flush`: input, 1 bit, taken branch or jump resolved in EX; kill the ID instruction.
REQ-011 Port `fwd_a`: output, 2 bits, registered select for the EX operand-A 3:1 mux.
REQ-012 Port `fwd_b`: output, 2 bits, registered select for the EX operand-B 3:1 mux.
REQ-013 Port `stall`: output, 1 bit, hold PC and IF/ID; insert a bubble into EX.
REQ-014 Port `stall_count`: output, 16 bits, saturating count of stall cycles.

Function
REQ-015 Select encoding SHALL be: 00 = register file, 01 = WB result, 10 = MEM result; 11 SHALL never be driven.
REQ-016 The block SHALL keep internal EX, MEM and WB shadow registers (valid, dst, regwrite, load); MEM <= EX and WB <= MEM every cycle unconditionally.
REQ-017 `stall` SHALL be combinational and equal ex_valid & ex_load & ex_dst!=0 & id_valid & ((id_uses_rs & id_rs==ex_dst) | (id_uses_rt & id_rt==ex_dst)).
REQ-018 On a posedge with flush=1, the block SHALL load EX with a bubble (valid=0, regwrite=0, load=0) and set fwd_a = fwd_b = 00; flush overrides stall.
REQ-019 On a posedge with stall=1 and flush=0, the block SHALL load EX with a bubble and set fwd_a = fwd_b = 00.
REQ-020 Otherwise EX SHALL capture id_valid, id_dst, id_regwrite & id_valid and id_load & id_valid.
REQ-021 In that same case the block SHALL register fwd_a with priority: 10 if id_uses_rs & ex_valid & ex_regwrite & ex_dst!=0 & ex_dst==id_rs; else 01 if the same test passes against MEM; else 00.
REQ-022 `fwd_b` SHALL follow the same rule as fwd_a using id_uses_rt and id_rt.
REQ-023 Register 0 SHALL never be a forwarding or stall source.
REQ-024 Forward selects SHALL be valid in the cycle the instruction occupies EX, giving one cycle of latency from ID.
REQ-025 After a load-use stall, the consumer SHALL re-evaluate next cycle, find the load in MEM and receive select 01 when it enters EX.
REQ-026 `stall_count` SHALL increment on each posedge where stall=1 and flush=0, and SHALL saturate at 0xFFFF.

Reset
REQ-027 While rst_n=0 at a posedge, all shadow valid/regwrite/load bits SHALL clear, fwd_a = fwd_b = 00, and stall_count = 0.
REQ-028 `stall` SHALL read 0 in the cycle after reset.
REQ-029 Reset asserted mid-stall SHALL drop the stall in the next cycle.

Structure
REQ-030 A shared package SHALL hold the FWD_RF (00), FWD_WB (01) and FWD_MEM (10) constants and REG_AW = 5.
REQ-031 One sub-module, `hazard_cmp`, SHALL perform the qualified match (use, valid, regwrite, nonzero, equal) and be instantiated 4x: rs/rt against EX/MEM.
REQ-032 fwd_a and fwd_b SHALL drive the existing 1-bit-parameterised 3:1 mux selects directly.

Verification
REQ-033 Back-to-back dependency: ADD to r3, then SUB reading rs=r3 -> fwd_a=10 while SUB is in EX; fwd_b=00.
REQ-034 Distance-2 dependency: ADD to r3, NOP, then OR reading rt=r3 -> fwd_b=01.
REQ-035 Double hit: ADD r5, ADD r5, then AND reading rs=r5 -> fwd_a=10, because MEM beats WB.
REQ-036 Load-use: LW to r4, then ADD reading rs=r4 -> stall=1 for exactly 1 cycle, then fwd_a=01, and stall_count increments by 1.
REQ-037 Load-use with flush in the same cycle -> EX bubble, fwd selects 00, and stall_count unchanged.
REQ-038 Zero register: write r0, then read r0 -> fwd 00 and no stall; rst_n=0 during a stall -> all outputs 0 on the next cycle.
